// File: rtl/stall_mem_resp_pkg.sv
// Shared encodings for the multi-cycle data-memory responder.
// Pure constants and types; no logic, no latency, no backpressure.
package stall_mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int CNT_W = 4;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/stall_mem_resp_mem_array_sp.sv
// Single-port 2^DEPTH_LOG2 x 16 storage: combinational read, write on clk edge.
// Zero-cycle read latency; no backpressure, always accepts the write enable.
module mem_array_sp #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [15:0]           wdata,
  output logic [15:0]           rdata
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Contents deliberately have no reset.
  logic [15:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/stall_mem_resp.sv
// Data-memory responder with LATENCY cycles from acceptance to the one-cycle Done pulse.
// Holds Stall while busy; requests arriving during BUSY are ignored, not queued.
module stall_mem_resp
  import stall_mem_resp_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  op;
  logic [DEPTH_LOG2-1:0] idx;
  logic [15:0]           wdata;

  logic                  accepting;
  logic                  req_any;
  logic                  req_bad;
  logic                  req_legal;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  mem_we;
  logic [15:0]           mem_rdata;
  logic [15:0]           unused_addr;

  assign accepting = (state == IDLE) || (state == DONE);
  assign req_any   = Rd | Wr;
  assign req_bad   = req_any & ((Rd & Wr) | Addr[0]);
  assign req_legal = req_any & ~req_bad;

  // Upper address bits simply alias onto the array.
  assign req_idx     = Addr[DEPTH_LOG2:1];
  assign unused_addr = Addr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_legal) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = req_legal ? BUSY : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= accepting & req_bad;
      if (accepting && req_legal) begin
        cnt <= CNT_LOAD;
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Request latches need no reset: they are only consumed after an acceptance.
  always_ff @(posedge clk) begin
    if (accepting && req_legal && !rst) begin
      op    <= Wr ? OP_WR : OP_RD;
      idx   <= req_idx;
      wdata <= DataIn;
    end
  end

  // The write lands on the edge that closes DONE, so a read accepted in that
  // same cycle observes the new data when it completes.
  assign mem_we = (state == DONE) && (op == OP_WR) && !rst;

  mem_array_sp #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (idx),
    .wdata(wdata),
    .rdata(mem_rdata)
  );

  assign Done    = (state == DONE);
  assign Stall   = (state == BUSY);
  assign DataOut = (Done && op == OP_RD) ? mem_rdata : 16'h0000;

endmodule

// File: tb/tb_stall_mem_resp.sv
// Randomized scoreboard bench for stall_mem_resp against a transaction-level memory model.
module tb_stall_mem_resp;

  parameter int LAT = 4;
  parameter int DL  = 10;
  localparam int WORDS = 1 << DL;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] Addr = 16'h0;
  logic [15:0] DataIn = 16'h0;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        err;

  stall_mem_resp #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          acc_c;
    int          done_c;
    int          abort_c;
    bit          is_rd;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t        eq[$];
  int          errq[$];
  logic [15:0] mdl [WORDS];
  bit          mval [WORDS];
  int          busy_done = -1;
  bit          pw_v = 0;
  int          pw_done = 0;
  int          pw_idx = 0;
  logic [15:0] pw_dat = 16'h0;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares the DUT's outputs every cycle against the scoreboard queues.
  bit exp_done, exp_stall, exp_err;
  always @(negedge clk) begin
    if (mon_en) begin
      while (eq.size() > 0 && eq[0].abort_c <= cyc) void'(eq.pop_front());
      exp_done  = (eq.size() > 0) && (eq[0].done_c == cyc);
      exp_stall = (eq.size() > 0) && (eq[0].acc_c < cyc) && (cyc < eq[0].done_c);
      check("done", 16'(Done), 16'(exp_done));
      check("stall", 16'(Stall), 16'(exp_stall));
      if (exp_done) begin
        if (Done && (!eq[0].is_rd || eq[0].chk))
          check(eq[0].is_rd ? "read_data" : "write_dataout", DataOut, eq[0].data);
        void'(eq.pop_front());
      end
      exp_err = (errq.size() > 0) && (errq[0] == cyc);
      if (exp_err) void'(errq.pop_front());
      check("err", 16'(err), 16'(exp_err));
    end
  end

  // Reference model: one transaction at a time; a write becomes visible once its
  // completion cycle has ended, unless a reset arrives first.
  task automatic model_req(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int   idx;
    if (cyc >= busy_done && (r || w)) begin
      if ((r && w) || a[0]) begin
        errq.push_back(cyc + 1);
      end else begin
        idx = int'(a[DL:1]);
        if (pw_v) begin
          mdl[pw_idx]  = pw_dat;
          mval[pw_idx] = 1'b1;
          pw_v = 0;
        end
        e.acc_c   = cyc;
        e.done_c  = cyc + LAT;
        e.abort_c = 1 << 30;
        e.is_rd   = r;
        e.chk     = r ? mval[idx] : 1'b1;
        e.data    = r ? mdl[idx] : 16'h0000;
        eq.push_back(e);
        if (w) begin
          pw_v    = 1;
          pw_idx  = idx;
          pw_dat  = d;
          pw_done = cyc + LAT;
        end
        busy_done = cyc + LAT;
      end
    end
  endtask

  task automatic model_reset();
    if (pw_v && cyc <= pw_done) pw_v = 0;
    foreach (eq[i]) if (eq[i].done_c > cyc) eq[i].abort_c = cyc + 1;
    busy_done = -1;
  endtask

  task automatic step(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d,
                      input bit do_rst);
    Rd = r; Wr = w; Addr = a; DataIn = d; rst = do_rst;
    if (do_rst) model_reset();
    else model_req(r, w, a, d);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic to_done();
    while (cyc < busy_done) idle();
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_dataout", DataOut, 16'h0);
    check("rst_done", 16'(Done), 16'h0);
    check("rst_stall", 16'(Stall), 16'h0);
    check("rst_err", 16'(err), 16'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    int hi, lo;
    hi = $urandom_range(0, (1 << (15 - DL)) - 1);
    lo = $urandom_range(0, 15);
    return 16'((hi << (DL + 1)) | (lo << 1));
  endfunction

  initial begin
    logic [15:0] a;
    int          k, n;

    rst = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    mon_en = 1;
    check_reset_outputs();

    // Write then read back.
    step(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    to_done(); idle();
    step(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    to_done(); idle();

    // Back-to-back read presented in the write's completion cycle.
    step(1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0);
    to_done();
    step(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
    to_done(); idle();

    // Illegal requests leave storage alone.
    step(1'b0, 1'b1, 16'h0004, 16'h7777, 1'b0);
    to_done(); idle();
    step(1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b0);
    step(1'b1, 1'b0, 16'h0003, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'h0005, 16'hDEAD, 1'b0);
    idle();
    step(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
    to_done(); idle();

    // Requests during BUSY are ignored.
    step(1'b0, 1'b1, 16'h0040, 16'hCAFE, 1'b0);
    while (cyc < busy_done)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
    idle();
    step(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
    to_done(); idle();

    // Reset while a write is in flight.
    step(1'b0, 1'b1, 16'h0030, 16'h5555, 1'b0);
    to_done(); idle();
    step(1'b0, 1'b1, 16'h0030, 16'hAAAA, 1'b0);
    if (LAT > 2) idle();
    step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check_reset_outputs();
    step(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
    to_done(); idle();

    // Address aliasing above the array size.
    a = 16'((1 << (DL + 1)) | 2);
    step(1'b0, 1'b1, a, 16'h0F0F, 1'b0);
    to_done(); idle();
    step(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0);
    to_done(); idle();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 19);
      if (cyc < busy_done && k < 17) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
      end else if (k == 0 && cyc != busy_done) begin
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      end else if (k <= 2) begin
        if (k == 1) step(1'b1, 1'b1, rand_addr(), 16'($urandom), 1'b0);
        else step(1'($urandom_range(0, 1)) ? 1'b1 : 1'b0, 1'b0, rand_addr() | 16'h1, 16'h0, 1'b0);
      end else if (k <= 5) begin
        idle();
      end else begin
        if ($urandom_range(0, 1) == 1) step(1'b1, 1'b0, rand_addr(), 16'h0, 1'b0);
        else step(1'b0, 1'b1, rand_addr(), 16'($urandom), 1'b0);
      end
    end

    n = 0;
    while ((eq.size() > 0 || errq.size() > 0) && n < 64) begin
      idle();
      n++;
    end
    idle();
    check("drain_pending", 16'(eq.size() + errq.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
